// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if: request/flit-type inputs from the input units and
// grant/fire/credit status from one output-port arbiter.
interface output_port_arbiter_if #(
  parameter int NUM_INPUTS = 5,
  parameter int BUF_DEPTH  = 4
);
  localparam int OW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [NUM_INPUTS-1:0] i_req;
  logic [NUM_INPUTS-1:0] i_head;
  logic [NUM_INPUTS-1:0] i_tail;
  logic                  i_credit_ret;
  logic [NUM_INPUTS-1:0] o_grant;
  logic [OW-1:0]         o_owner;
  logic                  o_fire;
  logic                  o_busy;
  logic [CW-1:0]         o_credits;
  logic                  o_credit_err;
  logic                  o_timeout;
  modport master (
    output i_req, i_head, i_tail, i_credit_ret,
    input  o_grant, o_owner, o_fire, o_busy, o_credits, o_credit_err, o_timeout
  );
  modport slave (
    input  i_req, i_head, i_tail, i_credit_ret,
    output o_grant, o_owner, o_fire, o_busy, o_credits, o_credit_err, o_timeout
  );
endinterface

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin wormhole arbiter with credit flow control for one output port.
// Define LOCK_TIMEOUT_EN to compile in the forced release of a stalled owner after TIMEOUT idle cycles.
module output_port_arbiter #(
  parameter int NUM_INPUTS = 5,
  parameter int BUF_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  output_port_arbiter_if.slave bus
);
  localparam int OW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                r_state;
  logic [NUM_INPUTS-1:0] r_grant;
  logic [NUM_INPUTS-1:0] w_cand;
  logic [OW-1:0]         r_owner;
  logic [OW-1:0]         r_rr_ptr;
  logic [OW-1:0]         w_pick;
  logic [OW-1:0]         w_next_ptr;
  logic [CW-1:0]         r_credits;
  logic                  r_credit_err;
  logic                  w_found;
  logic                  w_has_credit;
  logic                  w_fire;
  logic                  w_release;
  logic                  w_to_rel;
  logic                  w_timeout;
  assign w_cand       = bus.i_req & bus.i_head;
  assign w_has_credit = r_credits != '0;
  assign w_fire       = r_state == LOCKED && bus.i_req[r_owner] && w_has_credit;
  assign w_next_ptr   = r_owner == OW'(NUM_INPUTS - 1) ? '0 : r_owner + 1'b1;
  assign w_release    = (w_fire && bus.i_tail[r_owner]) || w_to_rel;
  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--)
      if (w_cand[(int'(r_rr_ptr) + k) % NUM_INPUTS]) begin
        w_found = 1'b1;
        w_pick  = OW'((int'(r_rr_ptr) + k) % NUM_INPUTS);
      end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if (r_state == IDLE) begin
      if (w_found && w_has_credit) begin
        r_state <= LOCKED;
        r_grant <= NUM_INPUTS'(1) << w_pick;
        r_owner <= w_pick;
      end
    end else if (w_release) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_owner  <= '0;
      r_rr_ptr <= w_next_ptr;
    end
  end
  // A return that arrives with a full count and nothing leaving is an overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_credits    <= CW'(BUF_DEPTH);
      r_credit_err <= 1'b0;
    end else if (bus.i_credit_ret && !w_fire) begin
      if (r_credits == CW'(BUF_DEPTH))
        r_credit_err <= 1'b1;
      else
        r_credits <= r_credits + 1'b1;
    end else if (w_fire && !bus.i_credit_ret) begin
      r_credits <= r_credits - 1'b1;
    end
  end
`ifdef LOCK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_idle_cnt;
  logic          r_timeout;
  assign w_to_rel  = r_state == LOCKED && !bus.i_req[r_owner] && r_idle_cnt == TW'(TIMEOUT - 1);
  assign w_timeout = r_timeout;
  always_ff @(posedge clk) begin
    if (!reset_n || r_state != LOCKED || bus.i_req[r_owner] || w_to_rel)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + 1'b1;
    r_timeout <= reset_n && w_to_rel;
  end
`else
  assign w_to_rel  = 1'b0;
  assign w_timeout = 1'b0;
`endif
  assign bus.o_grant      = r_grant;
  assign bus.o_owner      = r_owner;
  assign bus.o_fire       = w_fire;
  assign bus.o_busy       = r_state == LOCKED;
  assign bus.o_credits    = r_credits;
  assign bus.o_credit_err = r_credit_err;
  assign bus.o_timeout    = w_timeout;
endmodule
